// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - IF-stage fetch types and AXI encodings
package if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        HOLD
    } fetch_state_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage PC sequencing and single-outstanding AXI4 instruction read master
module if_fetch_ctrl #(
    parameter int                pc_size  = 32,
    parameter int                DATA_W   = 32,
    parameter logic [3:0]        AXI_ID   = 4'd0,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(if_pkg::NOP_INST)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [pc_size-1:0] pc_q,
    output logic [pc_size-1:0] pc_d,
    output logic               pc_we,
    input  logic               redirect_valid,
    input  logic [pc_size-1:0] redirect_pc,
    output logic [3:0]         ARID,
    output logic [31:0]        ARADDR,
    output logic [3:0]         ARLEN,
    output logic [2:0]         ARSIZE,
    output logic [1:0]         ARBURST,
    output logic               ARVALID,
    input  logic               ARREADY,
    input  logic [3:0]         RID,
    input  logic [31:0]        RDATA,
    input  logic [1:0]         RRESP,
    input  logic               RLAST,
    input  logic               RVALID,
    output logic               RREADY,
    output logic [DATA_W-1:0]  inst_o,
    output logic [pc_size-1:0] inst_pc_o,
    output logic               inst_valid_o,
    input  logic               id_ready,
    output logic               fetch_err_o
);
    import if_pkg::*;

    fetch_state_e       r_state;
    logic               r_flush;
    logic [pc_size-1:0] r_redir_pc;
    logic [pc_size-1:0] r_ar_addr;
    logic [DATA_W-1:0]  r_inst;
    logic [pc_size-1:0] r_inst_pc;
    logic               r_fetch_err;

    logic               w_beat;
    logic               w_resp_err;
    logic [pc_size-1:0] w_pc_inc;
    logic               w_drop;

    // A beat carrying a foreign ID is not ours; with one request in flight it never occurs.
    assign w_beat     = (r_state == DATA) && RVALID && RLAST && (RID == AXI_ID);
    assign w_resp_err = (RRESP != AXI_RESP_OKAY);
    assign w_pc_inc   = r_ar_addr + pc_size'(4);
    assign w_drop     = r_flush || redirect_valid;

    assign ARID         = AXI_ID;
    assign ARADDR       = 32'(r_ar_addr);
    assign ARLEN        = 4'd0;
    assign ARSIZE       = AXI_SIZE_WORD;
    assign ARBURST      = AXI_BURST_INCR;
    assign ARVALID      = (r_state == ADDR);
    assign RREADY       = (r_state == DATA);
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign inst_valid_o = (r_state == HOLD) && !redirect_valid;
    assign fetch_err_o  = r_fetch_err;

    always_comb begin
        pc_we = 1'b0;
        pc_d  = pc_q;
        if (redirect_valid && (r_state == IDLE || r_state == HOLD)) begin
            pc_we = 1'b1;
            pc_d  = redirect_pc;
        end else if (w_beat) begin
            pc_we = 1'b1;
            if (redirect_valid)
                pc_d = redirect_pc;
            else if (r_flush)
                pc_d = r_redir_pc;
            else
                pc_d = w_pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_flush     <= 1'b0;
            r_redir_pc  <= '0;
            r_ar_addr   <= '0;
            r_inst      <= '0;
            r_inst_pc   <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_fetch_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state   <= ADDR;
                    r_ar_addr <= redirect_valid ? redirect_pc : pc_q;
                end
                ADDR: begin
                    // The request stays on the bus; a redirect only marks its beat stale.
                    if (redirect_valid) begin
                        r_flush    <= 1'b1;
                        r_redir_pc <= redirect_pc;
                    end
                    if (ARREADY)
                        r_state <= DATA;
                end
                DATA: begin
                    if (w_beat && w_drop) begin
                        r_flush   <= 1'b0;
                        r_ar_addr <= redirect_valid ? redirect_pc : r_redir_pc;
                        r_state   <= ADDR;
                    end else if (w_beat) begin
                        r_inst      <= w_resp_err ? NOP_INST : DATA_W'(RDATA);
                        r_inst_pc   <= r_ar_addr;
                        r_fetch_err <= w_resp_err;
                        r_state     <= HOLD;
                    end else if (redirect_valid) begin
                        r_flush    <= 1'b1;
                        r_redir_pc <= redirect_pc;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        r_ar_addr <= redirect_pc;
                        r_state   <= ADDR;
                    end else if (id_ready) begin
                        r_ar_addr <= pc_q;
                        r_state   <= ADDR;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Sequences the IF-stage program counter register and the instruction-memory AXI4 read master.
- Issues one single-beat AXI read per instruction from the current PC and presents the returned word to ID with a valid/ready handshake.
- Drives the PC register's write enable and next value: PC+4 on a good fetch, or the target on a redirect.
- Discards in-flight fetches that a branch/jump redirect makes stale.

Parameters:
- pc_size, 32, PC/address width (from parameters.svh)
- DATA_W, 32, AXI read data width
- AXI_ID, 4'd0, constant ARID driven on every request
- NOP_INST, 32'h0000_0013, word substituted on error responses

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-low
- pc_q  in  pc_size  current PC from PC register output
- pc_d  out  pc_size  next PC to PC register input
- pc_we  out  1  PC register write enable; when low the register reloads its hold input (tied to pc_q)
- redirect_valid  in  1  branch/jump taken, one-cycle pulse from EX
- redirect_pc  in  pc_size  redirect target
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  4/32/4/3/2/1  AXI AR channel
- ARREADY  in  1
- RID/RDATA/RRESP/RLAST/RVALID  in  4/32/2/1/1  AXI R channel
- RREADY  out  1
- inst_o  out  DATA_W  fetched instruction
- inst_pc_o  out  pc_size  address of inst_o
- inst_valid_o  out  1  instruction available
- id_ready  in  1  ID accepts (low = stall)
- fetch_err_o  out  1  one-cycle pulse on RRESP != OKAY

Behaviour:
- Reset (rst low, async): state IDLE; ARVALID=0, RREADY=0, inst_valid_o=0, pc_we=0, fetch_err_o=0, flush_q=0, ar_addr_q=0, inst_o=0, inst_pc_o=0.
- Constants: ARLEN=0, ARSIZE=3'b010, ARBURST=INCR, ARID=AXI_ID.
- IDLE: next cycle goes to ADDR and captures ar_addr_q<=pc_q.
- ADDR: ARVALID=1, ARADDR=ar_addr_q, both stable until ARREADY. On ARREADY, go to DATA.
- DATA: RREADY=1. On RVALID&RLAST:
  - If flush_q is set, drop the data, clear flush_q, pc_we=1, pc_d=redir_pc_q, go to ADDR with ar_addr_q<=redir_pc_q.
  - Otherwise latch inst_o=RDATA (NOP_INST and fetch_err_o pulse if RRESP!=0), inst_pc_o=ar_addr_q, pc_we=1, pc_d=ar_addr_q+4, go to HOLD.
- HOLD: inst_valid_o=1 & !redirect_valid. On id_ready&inst_valid_o, go to ADDR with ar_addr_q<=pc_q. With id_ready low, hold all outputs.
- Latency: ARVALID to earliest inst_valid_o is 2 cycles with zero-wait memory. Best throughput is one instruction per 3 cycles; only one request is outstanding.
- Redirect handling (redirect_valid; priority over stall):
  - IDLE or HOLD: pc_we=1, pc_d=redirect_pc, the held instruction is dropped, go to ADDR with ar_addr_q<=redirect_pc.
  - ADDR or DATA: set flush_q, redir_pc_q<=redirect_pc. ARVALID/ARADDR are never withdrawn; the stale beat is discarded on return.
  - Pending redirect with flush_q already set: the newer target overwrites redir_pc_q.
  - Same cycle as the returning RVALID&RLAST in DATA: that beat is discarded, the target from this cycle is used.
- PC wrap: pc_d = ar_addr_q+4, modulo 2^pc_size.
- pc_we is combinational and low in every cycle not listed above.
- Mid-operation reset: returns to IDLE and drops any outstanding transaction. The interconnect is reset on the same rst.

Decomposition:
- Package if_pkg: fetch_state_e {IDLE, ADDR, DATA, HOLD}, AXI_BURST_INCR, AXI_SIZE_WORD, AXI_RESP_OKAY, NOP_INST.
- No sub-module. pc_reg is instantiated beside this block in the IF stage; pc_origin is tied to pc_q.

Test Plan:
- Reset release, pc_q=0, ARREADY and RVALID returned the cycle after each request -> ARADDR=0, inst_o=RDATA, inst_pc_o=0, pc_we with pc_d=4; next ARADDR=4.
- id_ready low for 5 cycles in HOLD -> inst_valid_o, inst_o and inst_pc_o stable; no new ARVALID; pc_we=0.
- redirect_valid with redirect_pc=0x100 while ARVALID is waiting 3 cycles for ARREADY -> ARADDR stays at old PC; the returned beat is dropped (no inst_valid_o); next ARADDR=0x100; pc_d=0x100.
- Redirect to 0x200 in HOLD with id_ready=1 -> inst_valid_o=0 that cycle, pc_d=0x200, pc_we=1, next ARADDR=0x200.
- RRESP=2'b10 on the fetch of 0x40 -> inst_o=0x00000013, fetch_err_o one pulse, pc_d=0x44.
- rst asserted in DATA -> ARVALID=RREADY=inst_valid_o=0 immediately; after release, ARADDR=pc_q.
